riscv_divider_if: RTL



---
 rtl/riscv_divider_pkg.sv | 40 ++++
 rtl/riscv_div_core.sv | 97 +++++++++
 rtl/riscv_divider_if.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_divider_pkg.sv
// Shared definitions for the memory-mapped iterative divider slave.
// Register indices are HADDR[4:2]; FSM encoding is shared with the core.
package riscv_divider_pkg;

    localparam logic [2:0] IDX_DIVIDEND  = 3'd0;
    localparam logic [2:0] IDX_DIVISOR   = 3'd1;
    localparam logic [2:0] IDX_CTRL      = 3'd2;
    localparam logic [2:0] IDX_STATUS    = 3'd3;
    localparam logic [2:0] IDX_QUOTIENT  = 3'd4;
    localparam logic [2:0] IDX_REMAINDER = 3'd5;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DBZ  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

    typedef struct packed {
        logic       write;
        logic [2:0] idx;
        logic       size_ok;
    } dp_t;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/riscv_div_core.sv
// Radix-2 restoring divider: 32 CALC cycles then one sign-fix cycle.
// Divide-by-zero bypasses CALC and returns all-ones / dividend.
module riscv_div_core
    import riscv_divider_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state;
    logic [5:0]  cnt;
    logic [31:0] r;
    logic [31:0] q;
    logic [31:0] d_mag;
    logic [31:0] dvd_orig;
    logic        neg_q;
    logic        neg_r;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] next_r;
    logic [31:0] next_q;

    always_comb begin
        shifted = {r, q[31]};
        diff    = shifted - {1'b0, d_mag};
        ge      = ~diff[32];
        next_r  = ge ? diff[31:0] : shifted[31:0];
        next_q  = {q[30:0], ge};
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            r         <= '0;
            q         <= '0;
            d_mag     <= '0;
            dvd_orig  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        r        <= '0;
                        q        <= mag(dividend, signed_op);
                        d_mag    <= mag(divisor, signed_op);
                        dvd_orig <= dividend;
                        neg_q    <= signed_op & (dividend[31] ^ divisor[31]);
                        neg_r    <= signed_op & dividend[31];
                        cnt      <= '0;
                        done     <= 1'b0;
                        dbz      <= (divisor == '0);
                        state    <= (divisor == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r   <= next_r;
                    q   <= next_q;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (dbz) begin
                        quotient  <= '1;
                        remainder <= dvd_orig;
                    end else begin
                        quotient  <= neg_q ? (~q + 32'd1) : q;
                        remainder <= neg_r ? (~r + 32'd1) : r;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/riscv_divider_if.sv
// AHB-Lite slave front end: data-phase register, register file,
// result-read stalls and two-cycle ERROR responses around riscv_div_core.
module riscv_divider_if
    import riscv_divider_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              sl_HSEL,
    input  logic              sl_HREADY,
    input  logic [1:0]        sl_HTRANS,
    input  logic [2:0]        sl_HBURST,
    input  logic [2:0]        sl_HSIZE,
    input  logic [W_ADDR-1:0] sl_HADDR,
    input  logic              sl_HWRITE,
    input  logic [W_DATA-1:0] sl_HWDATA,
    output logic              out_sl_HREADY,
    output logic [1:0]        out_sl_HRESP,
    output logic [W_DATA-1:0] out_sl_HRDATA
);

    dp_t         dp;
    logic        dp_valid;
    logic        err2;
    logic [31:0] dividend;
    logic [31:0] divisor;

    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] quotient;
    logic [31:0] remainder;

    logic        accept;
    logic        is_rw;
    logic        is_ro;
    logic        unmapped;
    logic        dp_err;
    logic        dp_stall;
    logic        hready_int;
    logic        wr_en;
    logic        start;
    logic [31:0] rdata;

    logic        unused_bits;
    assign unused_bits = ^{sl_HBURST, sl_HTRANS[0],
                           sl_HADDR[W_ADDR-1:5], sl_HADDR[1:0]};

    assign accept = sl_HSEL & sl_HREADY & sl_HTRANS[1];

    always_comb begin
        is_rw    = (dp.idx <= IDX_CTRL);
        is_ro    = (dp.idx >= IDX_STATUS) && (dp.idx <= IDX_REMAINDER);
        unmapped = (dp.idx > IDX_REMAINDER);
        dp_err   = dp_valid & (~dp.size_ok | unmapped
                   | (dp.write & is_ro) | (dp.write & is_rw & busy));
        dp_stall = dp_valid & ~dp_err & ~dp.write & busy
                   & ((dp.idx == IDX_QUOTIENT) | (dp.idx == IDX_REMAINDER));
        hready_int = ~(dp_err | dp_stall);
        wr_en    = dp_valid & dp.write & ~dp_err;
        start    = wr_en & (dp.idx == IDX_CTRL) & sl_HWDATA[CTRL_START];
    end

    always_comb begin
        rdata = '0;
        if (dp_valid && !dp.write && hready_int) begin
            unique case (1'b1)
                dp.idx == IDX_DIVIDEND:  rdata = dividend;
                dp.idx == IDX_DIVISOR:   rdata = divisor;
                dp.idx == IDX_STATUS:    rdata = {29'd0, dbz, done, busy};
                dp.idx == IDX_QUOTIENT:  rdata = quotient;
                dp.idx == IDX_REMAINDER: rdata = remainder;
                default:                 rdata = '0;
            endcase
        end
    end

    assign out_sl_HREADY = hready_int;
    assign out_sl_HRESP  = (dp_err | err2) ? HRESP_ERROR : HRESP_OKAY;
    assign out_sl_HRDATA = rdata;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp       <= '0;
            err2     <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
        end else begin
            err2 <= dp_err;
            // ERROR first cycle drops the transfer and ignores any new address
            if (dp_err) begin
                dp_valid <= 1'b0;
            end else if (hready_int) begin
                dp_valid <= accept;
                if (accept) begin
                    dp.write   <= sl_HWRITE;
                    dp.idx     <= sl_HADDR[4:2];
                    dp.size_ok <= (sl_HSIZE == HSIZE_WORD);
                end
            end
            if (wr_en && dp.idx == IDX_DIVIDEND)
                dividend <= sl_HWDATA;
            if (wr_en && dp.idx == IDX_DIVISOR)
                divisor <= sl_HWDATA;
        end
    end

    riscv_div_core u_core (
        .clk       (HCLK),
        .rst       (HRESET),
        .start     (start),
        .signed_op (sl_HWDATA[CTRL_SIGNED]),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule
